// File: rtl/aib_link_bringup_seq_pkg.sv
// Shared types and constants for the AIB link bring-up sequencer.
// State and error encodings are visible on debug outputs, so they are fixed here.
package aib_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CONF = 3'd1,
        ARST = 3'd2,
        LOCK = 3'd3,
        MACR = 3'd4,
        ALGN = 3'd5,
        UP   = 3'd6,
        ERR  = 3'd7
    } seq_state_e;

    localparam logic [2:0] NO_ERR    = 3'd0;
    localparam logic [2:0] NOEN      = 3'd1;
    localparam logic [2:0] LOCK_TO   = 3'd2;
    localparam logic [2:0] MACR_TO   = 3'd3;
    localparam logic [2:0] ALGN_TO   = 3'd4;
    localparam logic [2:0] MACR_LOST = 3'd5;
    localparam logic [2:0] ALGN_LOST = 3'd6;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // States whose dwell is bounded by the timer.
    function automatic logic timed_state(input seq_state_e s);
        return (s == CONF) || (s == ARST) || (s == LOCK) || (s == MACR) || (s == ALGN);
    endfunction

endpackage

// File: rtl/aib_link_bringup_seq_if.sv
// Control/status bundle between the bring-up sequencer (master) and the
// AIB PHY / AXI bridge side (slave).
interface aib_link_bringup_seq_if #(
    parameter int NBR_CHNLS = 24
);
    logic                 start;
    logic                 retrain;
    logic [NBR_CHNLS-1:0] chnl_en;
    logic [NBR_CHNLS-1:0] tx_lock_done;
    logic [NBR_CHNLS-1:0] rx_lock_done;
    logic [NBR_CHNLS-1:0] fs_mac_rdy;
    logic [NBR_CHNLS-1:0] m_rx_align_done;

    logic                 i_conf_done;
    logic [NBR_CHNLS-1:0] ns_adapter_rstn;
    logic [NBR_CHNLS-1:0] ms_tx_dcc_dll_lock_req;
    logic [NBR_CHNLS-1:0] ms_rx_dcc_dll_lock_req;
    logic [NBR_CHNLS-1:0] ns_mac_rdy;
    logic                 link_up;
    logic                 link_err;
    logic [2:0]           err_code;
    logic [2:0]           seq_state;

    modport master (
        input  start, retrain, chnl_en, tx_lock_done, rx_lock_done,
               fs_mac_rdy, m_rx_align_done,
        output i_conf_done, ns_adapter_rstn, ms_tx_dcc_dll_lock_req,
               ms_rx_dcc_dll_lock_req, ns_mac_rdy, link_up, link_err,
               err_code, seq_state
    );

    modport slave (
        output start, retrain, chnl_en, tx_lock_done, rx_lock_done,
               fs_mac_rdy, m_rx_align_done,
        input  i_conf_done, ns_adapter_rstn, ms_tx_dcc_dll_lock_req,
               ms_rx_dcc_dll_lock_req, ns_mac_rdy, link_up, link_err,
               err_code, seq_state
    );

endinterface

// File: rtl/aib_link_bringup_seq_timer.sv
// Saturating up-counter with synchronous clear/load and terminal-count compare.
// Saturation keeps a stalled phase from wrapping back into a false terminal count.
module aib_seq_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (cnt != '1) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/aib_link_bringup_seq.sv
// AIB link bring-up sequencer: walks the PHY MAC-side controls from reset to
// link_up with bounded waits, then supervises the link until fault or retrain.
module aib_link_bringup_seq
    import aib_seq_pkg::*;
#(
    parameter int NBR_CHNLS    = 24,
    parameter int CFG_WAIT_CYC = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                   clk_wr,
    input  logic                   rst_wr_n,
    aib_link_bringup_seq_if.master lnk
);

    localparam int TW = $clog2(max2(CFG_WAIT_CYC, LOCK_TIMEOUT) + 1);
    localparam logic [TW-1:0] CFG_TC  = TW'(CFG_WAIT_CYC - 1);
    localparam logic [TW-1:0] LOCK_TC = TW'(LOCK_TIMEOUT - 1);

    seq_state_e           state;
    logic [NBR_CHNLS-1:0] en_q;
    logic                 start_q;
    logic                 rise_q;

    logic                 conf_done_q;
    logic [NBR_CHNLS-1:0] adpt_rstn_q;
    logic [NBR_CHNLS-1:0] tx_req_q;
    logic [NBR_CHNLS-1:0] rx_req_q;
    logic [NBR_CHNLS-1:0] mac_rdy_q;
    logic                 link_up_q;
    logic                 link_err_q;
    logic [2:0]           err_code_q;

    logic                 lock_ok;
    logic                 mac_ok;
    logic                 algn_ok;
    logic                 adv;
    logic                 tmr_clr;
    logic                 tmr_tc;
    logic [TW-1:0]        tc_val;

    // Disabled channels are masked out so their status can never hold up or fault the link.
    always_comb begin
        lock_ok = ((lnk.tx_lock_done & lnk.rx_lock_done & en_q) == en_q);
        mac_ok  = ((lnk.fs_mac_rdy & en_q) == en_q);
        algn_ok = ((lnk.m_rx_align_done & en_q) == en_q);
        tc_val  = ((state == CONF) || (state == ARST)) ? CFG_TC : LOCK_TC;
        adv     = 1'b0;
        case (state)
            CONF, ARST: adv = tmr_tc;
            LOCK:       adv = lock_ok;
            MACR:       adv = mac_ok;
            ALGN:       adv = algn_ok;
            default:    adv = 1'b0;
        endcase
        // Held clear outside timed states, so entry from IDLE starts at zero.
        tmr_clr = adv | ~timed_state(state);
    end

    aib_seq_timer #(.W(TW)) u_tmr (
        .clk    (clk_wr),
        .rst_n  (rst_wr_n),
        .clr    (tmr_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .tc_val (tc_val),
        .tc     (tmr_tc)
    );

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state       <= IDLE;
            en_q        <= '0;
            start_q     <= 1'b0;
            rise_q      <= 1'b0;
            conf_done_q <= 1'b0;
            adpt_rstn_q <= '0;
            tx_req_q    <= '0;
            rx_req_q    <= '0;
            mac_rdy_q   <= '0;
            link_up_q   <= 1'b0;
            link_err_q  <= 1'b0;
            err_code_q  <= NO_ERR;
        end else begin
            start_q <= lnk.start;
            rise_q  <= lnk.start & ~start_q;

            if ((state != IDLE) && lnk.retrain) begin
                state       <= IDLE;
                conf_done_q <= 1'b0;
                adpt_rstn_q <= '0;
                tx_req_q    <= '0;
                rx_req_q    <= '0;
                mac_rdy_q   <= '0;
                link_up_q   <= 1'b0;
                link_err_q  <= 1'b0;
                err_code_q  <= NO_ERR;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise_q) begin
                            if (lnk.chnl_en == '0) begin
                                state      <= ERR;
                                link_err_q <= 1'b1;
                                err_code_q <= NOEN;
                            end else begin
                                state       <= CONF;
                                en_q        <= lnk.chnl_en;
                                conf_done_q <= 1'b1;
                            end
                        end
                    end
                    CONF: begin
                        if (adv) begin
                            state       <= ARST;
                            adpt_rstn_q <= en_q;
                        end
                    end
                    ARST: begin
                        if (adv) begin
                            state    <= LOCK;
                            tx_req_q <= en_q;
                            rx_req_q <= en_q;
                        end
                    end
                    // In the wait phases the exit condition outranks a same-cycle timeout.
                    LOCK: begin
                        if (adv) begin
                            state     <= MACR;
                            mac_rdy_q <= en_q;
                        end else if (tmr_tc) begin
                            state      <= ERR;
                            link_err_q <= 1'b1;
                            err_code_q <= LOCK_TO;
                        end
                    end
                    MACR: begin
                        if (adv) begin
                            state <= ALGN;
                        end else if (tmr_tc) begin
                            state      <= ERR;
                            link_err_q <= 1'b1;
                            err_code_q <= MACR_TO;
                        end
                    end
                    ALGN: begin
                        if (adv) begin
                            state     <= UP;
                            link_up_q <= 1'b1;
                        end else if (tmr_tc) begin
                            state      <= ERR;
                            link_err_q <= 1'b1;
                            err_code_q <= ALGN_TO;
                        end
                    end
                    UP: begin
                        if (!mac_ok) begin
                            state      <= ERR;
                            link_up_q  <= 1'b0;
                            link_err_q <= 1'b1;
                            err_code_q <= MACR_LOST;
                        end else if (!algn_ok) begin
                            state      <= ERR;
                            link_up_q  <= 1'b0;
                            link_err_q <= 1'b1;
                            err_code_q <= ALGN_LOST;
                        end
                    end
                    ERR: begin
                        state <= ERR;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign lnk.i_conf_done            = conf_done_q;
    assign lnk.ns_adapter_rstn        = adpt_rstn_q;
    assign lnk.ms_tx_dcc_dll_lock_req = tx_req_q;
    assign lnk.ms_rx_dcc_dll_lock_req = rx_req_q;
    assign lnk.ns_mac_rdy             = mac_rdy_q;
    assign lnk.link_up                = link_up_q;
    assign lnk.link_err               = link_err_q;
    assign lnk.err_code               = err_code_q;
    assign lnk.seq_state              = state;

endmodule

// File: tb/tb_aib_link_bringup_seq.sv
// Scoreboard bench for aib_link_bringup_seq: stimulus queues the expected
// state transitions (cycle + full output image), a monitor checks every cycle.
module tb_aib_link_bringup_seq;
    import aib_seq_pkg::*;

    localparam int N   = 24;
    localparam int CFG = 16;
    localparam int LTO = 4096;
    localparam int V   = 9 + 4 * N;

    typedef struct {
        int           cyc;
        logic [2:0]   st;
        logic         conf;
        logic [N-1:0] rstn;
        logic [N-1:0] lock;
        logic [N-1:0] mac;
        logic         up;
        logic         err;
        logic [2:0]   code;
    } exp_t;

    logic clk_wr = 1'b0;
    logic rst_wr_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    always #5 clk_wr = ~clk_wr;
    always @(posedge clk_wr) cyc <= cyc + 1;

    aib_link_bringup_seq_if #(.NBR_CHNLS(N)) lnk ();

    aib_link_bringup_seq #(
        .NBR_CHNLS    (N),
        .CFG_WAIT_CYC (CFG),
        .LOCK_TIMEOUT (LTO)
    ) dut (
        .clk_wr   (clk_wr),
        .rst_wr_n (rst_wr_n),
        .lnk      (lnk)
    );

    function automatic logic [V-1:0] obs();
        return {lnk.seq_state, lnk.link_up, lnk.link_err, lnk.err_code, lnk.i_conf_done,
                lnk.ns_adapter_rstn, lnk.ms_tx_dcc_dll_lock_req, lnk.ms_rx_dcc_dll_lock_req,
                lnk.ns_mac_rdy};
    endfunction

    function automatic logic [V-1:0] pk(input exp_t e);
        return {e.st, e.up, e.err, e.code, e.conf, e.rstn, e.lock, e.lock, e.mac};
    endfunction

    task automatic chk(input string nm, input logic [V-1:0] act, input logic [V-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h cyc=%0d", nm, act, expv, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] st, input logic conf,
                        input logic [N-1:0] rstn, input logic [N-1:0] lock,
                        input logic [N-1:0] mac, input logic up, input logic err,
                        input logic [2:0] code);
        exp_t e;
        e.cyc = c; e.st = st; e.conf = conf; e.rstn = rstn; e.lock = lock;
        e.mac = mac; e.up = up; e.err = err; e.code = code;
        q.push_back(e);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk_wr);
    endtask

    task automatic set_status(input logic [N-1:0] v);
        lnk.tx_lock_done    = v;
        lnk.rx_lock_done    = v;
        lnk.fs_mac_rdy      = v;
        lnk.m_rx_align_done = v;
    endtask

    task automatic retrain_pulse();
        int r;
        @(negedge clk_wr);
        r = cyc;
        lnk.retrain = 1'b1;
        push(r + 1, IDLE, 1'b0, '0, '0, '0, 1'b0, 1'b0, NO_ERR);
        @(negedge clk_wr);
        lnk.retrain = 1'b0;
    endtask

    // Drives a fresh 0->1 start edge; returns the cycle stamp of that negedge.
    task automatic start_edge(output int s);
        lnk.start = 1'b0;
        @(negedge clk_wr);
        @(negedge clk_wr);
        s = cyc;
        lnk.start = 1'b1;
    endtask

    task automatic push_front_half(input int s, input logic [N-1:0] en);
        push(s + 2,  CONF, 1'b1, '0, '0, '0, 1'b0, 1'b0, NO_ERR);
        push(s + 18, ARST, 1'b1, en, '0, '0, 1'b0, 1'b0, NO_ERR);
        push(s + 34, LOCK, 1'b1, en, en, '0, 1'b0, 1'b0, NO_ERR);
    endtask

    // Monitor: every state change must match the head of the queue, in value and cycle;
    // between changes the whole output image must hold.
    initial begin : monitor
        exp_t       cur;
        exp_t       e;
        logic [2:0] prev_st;
        cur.cyc = 0; cur.st = IDLE; cur.conf = 1'b0; cur.rstn = '0; cur.lock = '0;
        cur.mac = '0; cur.up = 1'b0; cur.err = 1'b0; cur.code = NO_ERR;
        prev_st = IDLE;
        forever begin
            @(negedge clk_wr);
            if (lnk.seq_state !== prev_st) begin
                prev_st = lnk.seq_state;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_transition: got state=%0d exp=none cyc=%0d",
                             lnk.seq_state, cyc);
                end else begin
                    e = q.pop_front();
                    chk("transition_cycle", V'(cyc), V'(e.cyc));
                    chk("transition_outputs", obs(), pk(e));
                    cur = e;
                end
            end else begin
                chk("hold_outputs", obs(), pk(cur));
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk_wr);
        $display("FAIL watchdog: got cyc=%0d exp=finish before 20000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int           s;
        int           d;
        logic [N-1:0] en;

        lnk.start   = 1'b0;
        lnk.retrain = 1'b0;
        lnk.chnl_en = '0;
        set_status('1);
        rst_wr_n = 1'b1;
        #1 rst_wr_n = 1'b0;
        repeat (3) @(negedge clk_wr);
        chk("reset_outputs", obs(), '0);
        rst_wr_n = 1'b1;

        // No channels enabled: ERR/NOEN straight from IDLE.
        lnk.chnl_en = '0;
        start_edge(s);
        push(s + 2, ERR, 1'b0, '0, '0, '0, 1'b0, 1'b1, NOEN);
        wait_to(s + 6);
        retrain_pulse();

        // Full bring-up on 4 channels, disabled-channel drop ignored, then double drop.
        en = 24'h00000F;
        lnk.chnl_en = en;
        start_edge(s);
        push_front_half(s, en);
        push(s + 35, MACR, 1'b1, en, en, en, 1'b0, 1'b0, NO_ERR);
        push(s + 36, ALGN, 1'b1, en, en, en, 1'b0, 1'b0, NO_ERR);
        push(s + 37, UP,   1'b1, en, en, en, 1'b1, 1'b0, NO_ERR);
        wait_to(s + 45);
        lnk.fs_mac_rdy[20] = 1'b0;
        wait_to(s + 50);
        d = cyc;
        lnk.fs_mac_rdy[2]      = 1'b0;
        lnk.m_rx_align_done[2] = 1'b0;
        push(d + 1, ERR, 1'b1, en, en, en, 1'b0, 1'b1, MACR_LOST);
        wait_to(d + 4);
        retrain_pulse();
        set_status('1);

        // start still held high: no restart may follow the retrain.
        repeat (10) @(negedge clk_wr);

        // Lock never completes on channel 5: LOCK timeout.
        en = '1;
        lnk.chnl_en = en;
        lnk.rx_lock_done[5] = 1'b0;
        start_edge(s);
        push_front_half(s, en);
        push(s + 34 + LTO, ERR, 1'b1, en, en, '0, 1'b0, 1'b1, LOCK_TO);
        wait_to(s + 34 + LTO + 3);
        retrain_pulse();
        set_status('1);

        // Lock arrives in the very cycle the timeout would fire: exit wins.
        en = 24'h000001;
        lnk.chnl_en = en;
        lnk.tx_lock_done = '0;
        start_edge(s);
        push_front_half(s, en);
        push(s + 34 + LTO, MACR, 1'b1, en, en, en, 1'b0, 1'b0, NO_ERR);
        push(s + 35 + LTO, ALGN, 1'b1, en, en, en, 1'b0, 1'b0, NO_ERR);
        push(s + 36 + LTO, UP,   1'b1, en, en, en, 1'b1, 1'b0, NO_ERR);
        wait_to(s + 33 + LTO);
        lnk.tx_lock_done = '1;
        wait_to(s + 40 + LTO);
        retrain_pulse();

        // Async reset while stalled in MACR.
        en = 24'h800001;
        lnk.chnl_en = en;
        lnk.fs_mac_rdy[0] = 1'b0;
        start_edge(s);
        push_front_half(s, en);
        push(s + 35, MACR, 1'b1, en, en, en, 1'b0, 1'b0, NO_ERR);
        wait_to(s + 40);
        push(s + 41, IDLE, 1'b0, '0, '0, '0, 1'b0, 1'b0, NO_ERR);
        #2 rst_wr_n = 1'b0;
        lnk.start = 1'b0;
        #1 chk("async_reset_outputs", obs(), '0);
        wait_to(s + 43);
        rst_wr_n = 1'b1;
        set_status('1);
        wait_to(s + 48);
        chk("state_after_reset", V'(lnk.seq_state), V'(IDLE));

        // retrain in IDLE must do nothing (monitor would flag any transition).
        @(negedge clk_wr);
        lnk.retrain = 1'b1;
        @(negedge clk_wr);
        lnk.retrain = 1'b0;
        repeat (5) @(negedge clk_wr);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations: got=%0d left exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
